// File: rtl/xor_checksum_seq_pkg.sv
// Shared definitions for the XOR checksum sequencer: FSM encoding and checksum width.
package xor_checksum_seq_pkg;

    localparam int CHK_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/XOR_32.sv
// 32-bit bitwise XOR cell used as the checksum fold datapath.
module XOR_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Y
);

    assign Y = A ^ B;

endmodule

// File: rtl/xor_checksum_seq.sv
// Folds a job of len 32-bit words into an XOR checksum and pulses done with the result.
// Optional seed port enabled by defining XOR_CHK_SEED_EN.
module xor_checksum_seq
    import xor_checksum_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
`ifdef XOR_CHK_SEED_EN
    input  logic [CHK_W-1:0] seed,
`endif
    input  logic             in_valid,
    input  logic [CHK_W-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [CHK_W-1:0] result,
    output logic             parity,
    output logic [LEN_W-1:0] words_left
);

    state_e             state_q, state_d;
    logic [CHK_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   wl_q, wl_d;
    logic [CHK_W-1:0]   fold;
    logic [CHK_W-1:0]   init_val;

`ifdef XOR_CHK_SEED_EN
    assign init_val = seed;
`else
    assign init_val = '0;
`endif

    XOR_32 u_fold (
        .A (acc_q),
        .B (in_data),
        .Y (fold)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wl_q    <= wl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wl_d    = wl_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = init_val;
                    wl_d    = len;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // abort wins over a same-cycle transfer; the word is dropped
                if (abort) begin
                    acc_d   = '0;
                    wl_d    = '0;
                    state_d = IDLE;
                end else if (in_valid) begin
                    acc_d = fold;
                    wl_d  = wl_q - LEN_W'(1);
                    if (wl_q == LEN_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == ACCUM);
    assign busy       = (state_q == ACCUM) || (state_q == DONE);
    assign done       = (state_q == DONE);
    assign result     = acc_q;
    assign parity     = ^acc_q;
    assign words_left = wl_q;

endmodule

// File: tb/tb_xor_checksum_seq.sv
// Self-checking bench for xor_checksum_seq: vector table plus hand-written corner sequences,
// with a scoreboard queue popped on every done pulse.
module tb_xor_checksum_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready, busy, done, parity;
    logic [31:0]      result;
    logic [LEN_W-1:0] words_left;
`ifdef XOR_CHK_SEED_EN
    logic [31:0]      seed = '0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [32:0] sb[$];

    typedef struct {
        int               n;
        logic [3:0][31:0] w;
        logic [3:0][3:0]  gap;
        logic [31:0]      exp;
        logic             par;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    xor_checksum_seq #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .abort      (abort),
`ifdef XOR_CHK_SEED_EN
        .seed       (seed),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .parity     (parity),
        .words_left (words_left)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // scoreboard consumer: every done must match the oldest pending job
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h with no job pending at %0t", result, $time);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("sb_result", result, e[31:0]);
                chk("sb_parity", {31'd0, parity}, {31'd0, e[32]});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        len   = LEN_W'(v.n);
        start = 1'b1;
        sb.push_back({v.par, v.exp});
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < v.n; i++) begin
            for (int g = 0; g < int'(v.gap[i]); g++) begin
                in_valid = 1'b0;
                tick();
                chk("wl_hold", {24'd0, words_left}, 32'(v.n - i));
            end
            in_valid = 1'b1;
            in_data  = v.w[i];
            chk("in_ready_accum", {31'd0, in_ready}, 32'd1);
            tick();
            chk("wl_dec", {24'd0, words_left}, 32'(v.n - 1 - i));
        end
        in_valid = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("result_hold", result, v.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{3, {32'h0, 32'h00000001, 32'h0F0F0F0F, 32'hFFFF0000}, 16'h0000, 32'hF0F00F0E, 1'b1};
        vecs[1] = '{2, {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678}, 16'h0020, 32'h88888888, 1'b0};
        vecs[2] = '{1, {32'h0, 32'h0, 32'h0, 32'h80000000}, 16'h0000, 32'h80000000, 1'b1};
        vecs[3] = '{4, {32'h8, 32'h4, 32'h2, 32'h1}, 16'h0101, 32'h0000000F, 1'b0};
        vecs[4] = '{4, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 16'h0000, 32'h0, 1'b0};
        vecs[5] = '{0, {32'h0, 32'h0, 32'h0, 32'h0}, 16'h0000, 32'h0, 1'b0};
        vecs[6] = '{3, {32'h0, 32'h00000001, 32'hDEADBEEF, 32'hDEADBEEF}, 16'h0000, 32'h00000001, 1'b1};

        // reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_parity", {31'd0, parity}, 32'd0);
        chk("rst_words_left", {24'd0, words_left}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) run_vec(vecs[k]);

        // in_valid with no job active
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("idle_valid_no_effect", result, 32'h00000001);
        chk("idle_valid_busy", {31'd0, busy}, 32'd0);

        // abort together with the second transfer
        len = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAAA0000;
        tick();
        chk("abort_wl_pre", {24'd0, words_left}, 32'd3);
        in_data = 32'h5555FFFF; abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_wl", {24'd0, words_left}, 32'd0);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        tick();
        chk("abort_no_done_late", {31'd0, done}, 32'd0);

        // start during ACCUM and DONE ignored; abort in DONE ignored
        len = 8'd2; start = 1'b1;
        sb.push_back({1'b0, 32'h00FFFF00});
        tick();
        len = 8'd7;
        in_valid = 1'b1; in_data = 32'h0000FFFF;
        tick();
        chk("busy_start_wl", {24'd0, words_left}, 32'd1);
        len = 8'd9; in_data = 32'h00FF00FF;
        tick();
        in_data = 32'hFFFFFFFF; abort = 1'b1;
        chk("done_with_start_abort", {31'd0, done}, 32'd1);
        tick();
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);
        chk("ignored_start_wl", {24'd0, words_left}, 32'd0);
        tick();
        tick();
        chk("result_held", result, 32'h00FFFF00);

        // zero-length job
`ifdef XOR_CHK_SEED_EN
        seed = 32'hA5A5A5A5;
        sb.push_back({1'b0, 32'hA5A5A5A5});
`else
        sb.push_back({1'b0, 32'h0});
`endif
        len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
        chk("len0_done", {31'd0, done}, 32'd1);
        tick();
        chk("len0_in_ready_after", {31'd0, in_ready}, 32'd0);
`ifdef XOR_CHK_SEED_EN
        seed = 32'h0;
`endif

        // reset mid-job with five words outstanding
        len = 8'd6; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h12345678;
        tick();
        in_valid = 1'b0;
        chk("midjob_wl", {24'd0, words_left}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_wl", {24'd0, words_left}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        v = '{1, {32'h0, 32'h0, 32'h0, 32'h80000000}, 16'h0000, 32'h80000000, 1'b1};
        run_vec(v);

        repeat (3) tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
